// File: rtl/tdm_mux8to1.sv
// ---------------------------------------------------------------------------
// tdm_mux8to1
//   Transmit end of the 8-channel TDM link. A round-robin arbiter picks one of
//   eight valid/ready channels per cycle. The winner's data and 3-bit index
//   are captured in a one-entry output register that absorbs back-pressure
//   from the downstream 1-to-8 demux.
//
//   Build option:
//     TDM_MUX_FIXED_PRIO_EN  defined   -> strict fixed priority (lowest index
//                                         wins), no rotating pointer
//                            undefined -> round-robin (default)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   accept enable; low blocks new grants
//   in_valid   in   [7:0]     per-channel request
//   in_data    in   [8*DW-1:0] channel i at [i*DW +: DW]
//   in_ready   out  [7:0]     one-hot (or zero) accept strobe, combinational
//   out_valid  out  beat valid (output register FULL)
//   out_data   out  [DW-1:0]  beat data (demux D)
//   out_sel    out  [2:0]     beat channel index (demux S2..S0)
//   out_ready  in   downstream accept
//
// Output register states:
//   state | meaning
//   EMPTY | no beat held, out_valid=0
//   FULL  | beat held, out_valid=1, waiting for out_ready
// ---------------------------------------------------------------------------
module tdm_mux8to1 #(
    parameter int DW = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [7:0]      in_valid,
    input  logic [8*DW-1:0] in_data,
    output logic [7:0]      in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_sel,
    input  logic            out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [2:0]      sel_q, sel_d;
    logic [2:0]      grant_idx;
    logic            load;

`ifdef TDM_MUX_FIXED_PRIO_EN
    // Lowest-index requester wins; scanning downward lets the last hit stick.
    always_comb begin
        grant_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (in_valid[k]) begin
                grant_idx = 3'(k);
            end
        end
    end
`else
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx;
    logic       found;

    // Search ptr+1 .. ptr+8; the 3-bit add wraps modulo 8 on its own.
    always_comb begin
        grant_idx = 3'd0;
        found     = 1'b0;
        idx       = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && in_valid[idx]) begin
                grant_idx = idx;
                found     = 1'b1;
            end
        end
    end
`endif

    // Reset gating keeps in_ready at zero for as long as rst is held.
    assign load = ~rst & en & (|in_valid) & ((state_q == EMPTY) | out_ready);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

`ifndef TDM_MUX_FIXED_PRIO_EN
    // ptr resets to 7 so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 3'd7;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
`ifndef TDM_MUX_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        if (load) begin
            // Covers the simultaneous drain+load case, so beats have no gaps.
            state_d = FULL;
            data_d  = in_data[int'(grant_idx)*DW +: DW];
            sel_d   = grant_idx;
`ifndef TDM_MUX_FIXED_PRIO_EN
            ptr_d   = grant_idx;
`endif
        end else if ((state_q == FULL) && out_ready) begin
            // Drain only; data and sel keep their last values.
            state_d = EMPTY;
        end
    end

    // Output logic
    always_comb begin
        in_ready = 8'h00;
        if (load) begin
            in_ready[grant_idx] = 1'b1;
        end
        out_valid = (state_q == FULL);
        out_data  = data_q;
        out_sel   = sel_q;
    end

endmodule

// File: tb/tb_tdm_mux8to1.sv
module tb_tdm_mux8to1;

    localparam int DW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [7:0]      in_valid;
    logic [8*DW-1:0] in_data;
    logic [7:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_sel;
    logic            out_ready;

    tdm_mux8to1 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic       m_valid = 1'b0;
    logic [2:0] m_ptr   = 3'd7;
    logic [3:0] exp_q[$];   // {sel, data} of each accepted beat

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_grant(input logic [7:0] v, input logic [2:0] p);
        logic [2:0] g;
        g = 3'd0;
`ifdef TDM_MUX_FIXED_PRIO_EN
        for (int k = 0; k < 8; k++) begin
            if (v[k]) begin
                g = 3'(k);
                break;
            end
        end
`else
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] i;
            i = p + 3'(k);
            if (v[i]) begin
                g = i;
                break;
            end
        end
`endif
        return g;
    endfunction

    // Called just after a falling edge with inputs already driven. Checks
    // combinational outputs, scores any beat leaving on the coming edge,
    // advances the model across the edge, returns after the next falling edge.
    task automatic cycle();
        logic       e_load;
        logic [2:0] e_g;
        logic [7:0] e_ready;
        logic [3:0] beat;
        #1;
        e_load  = !rst && en && (|in_valid) && (!m_valid || out_ready);
        e_g     = model_grant(in_valid, m_ptr);
        e_ready = e_load ? (8'h01 << e_g) : 8'h00;
        chk("in_ready", in_ready, e_ready);
        chk("out_valid", out_valid, m_valid);
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                beat = exp_q.pop_front();
                chk("beat", {out_sel, out_data}, beat);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 3'd7;
            exp_q.delete();
        end else if (e_load) begin
            exp_q.push_back({e_g, in_data[e_g]});
            m_valid = 1'b1;
`ifndef TDM_MUX_FIXED_PRIO_EN
            m_ptr   = e_g;
`endif
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    logic [7:0] pat;

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 8'hFF; in_data = 8'h00; out_ready = 1'b1;
        @(negedge clk);

        // reset held with all channels requesting
        cycle();
        cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 8'h00);

        rst = 1'b0;
        #1 chk("first_grant", in_ready, 8'h01);
        cycle();
        chk("first_sel", out_sel, 0);

`ifndef TDM_MUX_FIXED_PRIO_EN
        // single channel 5
        in_valid = 8'h00;
        cycle();
        in_valid = 8'h20; in_data = 8'h20;
        #1 chk("single_ready", in_ready, 8'h20);
        cycle();
        in_valid = 8'h00;
        chk("single_valid", out_valid, 1);
        chk("single_sel", out_sel, 5);
        chk("single_data", out_data, 1);
        cycle();

        // round-robin wrap from reset
        pat = 8'b1011_0010;
        rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 8'hFF; in_data = pat;
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("rr_valid", out_valid, 1);
            chk("rr_sel", out_sel, k % 8);
            chk("rr_data", out_data, pat[k % 8]);
        end

        // back-pressure with channel 3 held
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        chk("bp_setup_sel", out_sel, 3);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("bp_ready", in_ready, 8'h00);
            cycle();
            chk("bp_sel", out_sel, 3);
            chk("bp_data", out_data, pat[3]);
        end
        out_ready = 1'b1;
        #1 chk("bp_resume_ready", in_ready, 8'h10);
        cycle();
        chk("bp_next_sel", out_sel, 4);
        chk("bp_next_valid", out_valid, 1);

        // enable gating: channel 4 beat drains with en low
        en = 1'b0;
        #1 chk("en_ready", in_ready, 8'h00);
        cycle();
        chk("en_drained", out_valid, 0);
        #1 chk("en_ready_idle", in_ready, 8'h00);
        cycle();
        en = 1'b1;
        #1 chk("en_resume_ready", in_ready, 8'h20);
        cycle();
        chk("en_resume_sel", out_sel, 5);

        // two requesters alternate under round-robin
        in_valid = 8'h44;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr44_sel", out_sel, (k % 2 == 0) ? 6 : 2);
        end
`else
        // fixed priority: channel 2 always beats channel 6
        in_valid = 8'h44; in_data = 8'h44;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("fp_sel", out_sel, 2);
            chk("fp_valid", out_valid, 1);
        end
`endif

        // random traffic scored against the model
        for (int k = 0; k < 300; k++) begin
            rst       = ($urandom_range(0, 49) == 0);
            en        = ($urandom_range(0, 5) != 0);
            in_valid  = 8'($urandom);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // drain
        rst = 1'b0; en = 1'b0; in_valid = 8'h00; out_ready = 1'b1;
        cycle();
        cycle();
        chk("sb_empty", exp_q.size(), 0);
        chk("final_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tdm_mux8to1.md
# tdm_mux8to1

Eight-channel time-division multiplexer. It is the transmit end of the 1-to-8 demux link: it arbitrates among eight valid/ready input channels and emits one registered beat per cycle. Each beat carries its data together with the 3-bit channel select (S2..S0) that the downstream demux decodes. A round-robin arbiter keeps sustained traffic fair, and a one-entry output register absorbs downstream back-pressure.

## Interface
Parameters:
- DW, 1, data width per channel (1 matches the demux D input).

Ports:
- clk  input  1  clock. All logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  accept enable. While low, no new channel is granted.
- in_valid  input  8  per-channel request. Bit i belongs to channel i.
- in_data  input  8*DW  channel data. Channel i occupies in_data[i*DW +: DW].
- in_ready  output  8  per-channel accept strobe. One-hot or zero, combinational.
- out_valid  output  1  output beat valid.
- out_data  output  DW  beat data. Drives the demux D input.
- out_sel  output  3  channel index of the beat. out_sel[2:0] maps to S2,S1,S0.
- out_ready  input  1  downstream accept.

## Operation
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- Load condition: load = en & (|in_valid) & (~out_valid | out_ready).
- Grant:
  - The grant is the first channel with in_valid set, searched in the order ptr+1, ptr+2, …, ptr+8, modulo 8.
  - The search wraps: with ptr=6 the order is 7,0,1,…,6.
  - in_ready[g] = load. All other in_ready bits are 0.
- On load:
  - out_data <= in_data of channel g.
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= g.
- Drain without a new load: when out_valid & out_ready & ~load, out_valid <= 0. out_data and out_sel keep their last values.
- Hold: when out_valid & ~out_ready, out_valid, out_data, out_sel and ptr are all frozen and in_ready is all 0.
- Channel transfer rule: a channel transfers only when in_valid[i] & in_ready[i] are both high in the same cycle. A channel whose in_valid falls before it is granted loses nothing and is simply not served.
- en low:
  - in_ready is all 0 and ptr is frozen.
  - A held beat still drains normally on out_ready.
- Demux pairing: out_sel and out_data together give a demux (EN=out_valid) its exact Y[out_sel]=out_data pattern.

## Timing
- Reset values, effective on the first clk edge with rst=1:
  - out_valid=0, out_data=0, out_sel=0.
  - ptr=7, so channel 0 has first priority after reset.
  - in_ready=0 for as long as rst is high.
- Latency: data accepted at edge N appears on out_data/out_sel with out_valid=1 after edge N, i.e. one cycle.
- Throughput: one beat per cycle while out_ready=1 and requests are present. There are no bubbles between beats, since a simultaneous drain and load is allowed.
- Sustained fairness: with all eight channels requesting continuously, each channel is served exactly once every 8 beats.
- Reset mid-operation: a held beat is discarded, out_valid drops after the reset edge, and ptr returns to 7.
- in_ready depends combinationally on in_valid, en, out_valid and out_ready. It has no combinational dependence on in_data.

## Configuration
- TDM_MUX_FIXED_PRIO_EN:
  - Defined: the arbiter is strict fixed priority, with the lowest-index requesting channel always winning. ptr is not implemented and out_sel still reports the granted index.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold rst=1 with all in_valid=8'hFF for 2 cycles -> out_valid=0, out_sel=0, out_data=0, in_ready=0. After release, the first grant is channel 0.
- Single channel: in_valid=8'h20, channel 5 data=1, out_ready=1 -> in_ready=8'h20. Next cycle out_valid=1, out_sel=5, out_data=1.
- Round-robin wrap: in_valid=8'hFF held, out_ready=1, DW=1 data pattern 8'b10110010 -> out_sel runs 0,1,2,…,7,0 on consecutive cycles with out_data matching the channel bits and no gaps.
- Back-pressure:
  - Setup: out_valid=1 with out_sel=3, out_ready=0 for 4 cycles, in_valid=8'hFF.
  - During the stall: out_sel=3 and out_data are stable, and in_ready=0.
  - On out_ready=1: the next beat is channel 4 in the same cycle the channel 3 beat drains.
- Enable gating: with a beat held, drop en and pulse out_ready -> the beat drains, out_valid goes to 0 and in_ready stays 0. Raising en resumes from ptr+1.
- Fixed priority (TDM_MUX_FIXED_PRIO_EN defined): in_valid=8'h44 held, out_ready=1 -> out_sel=2 on every beat and channel 6 is never granted.
